// File: rtl/adv_timer_event_gen_if.sv
// Event-router link: level request with per-line accept, plus per-line pending count and overflow status.
interface adv_timer_event_gen_if #(
  parameter int N_EVT = 4,
  parameter int CNT_W = 3
) ();
  logic [N_EVT-1:0]       evt_req_o;
  logic [N_EVT-1:0]       evt_ack_i;
  logic [N_EVT*CNT_W-1:0] evt_pend_o;
  logic [N_EVT-1:0]       evt_ovf_o;

  modport master (
    output evt_req_o,
    output evt_pend_o,
    output evt_ovf_o,
    input  evt_ack_i
  );

  modport slave (
    input  evt_req_o,
    input  evt_pend_o,
    input  evt_ovf_o,
    output evt_ack_i
  );
endinterface

// File: rtl/adv_timer_event_gen.sv
// Turns selected timer PWM edges into queued, lossless req/ack events for the SoC event router.
// Latency: a PWM edge driven at clock t raises req / bumps the count at clock t+1.
// Backpressure: up to 2^CNT_W-1 events queue per line; beyond that events drop and ovf sticks.
module adv_timer_event_gen #(
  parameter int N_SRC = 16,
  parameter int N_EVT = 4,
  parameter int SEL_W = 4,
  parameter int CNT_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC-1:0]       pwm_i,
  input  logic [N_EVT-1:0]       cfg_en_i,
  input  logic [N_EVT*SEL_W-1:0] cfg_sel_i,
  input  logic [N_EVT*2-1:0]     cfg_edge_i,
  input  logic [N_EVT-1:0]       cfg_clr_i,
  adv_timer_event_gen_if.master  evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_EVT-1:0]       req;
  logic [N_EVT-1:0]       ovf;
  logic [N_EVT*CNT_W-1:0] pend;

  for (genvar n = 0; n < N_EVT; n++) begin : g_evt
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_q;
    logic [1:0]       mode;
    logic             samp;
    logic             prev_q;
    logic             vld_q;
    logic             edge_hit;
    logic             hit;
    logic             acc;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    assign sel  = cfg_sel_i[n*SEL_W +: SEL_W];
    assign mode = cfg_edge_i[n*2 +: 2];

    always_comb begin
      samp = 1'b0;
      if (int'(sel) < N_SRC) samp = pwm_i[sel];
    end

    always_comb begin
      edge_hit = 1'b0;
      case (mode)
        2'b00:   edge_hit = samp & ~prev_q;
        2'b01:   edge_hit = ~samp & prev_q;
        2'b10:   edge_hit = samp ^ prev_q;
        default: edge_hit = 1'b0;
      endcase
    end

    // prev_q belongs to the old source for one cycle after a select change, so that edge is ignored.
    assign hit = cfg_en_i[n] & vld_q & (sel == sel_q) & edge_hit;
    assign acc = req[n] & evt.evt_ack_i[n];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        prev_q <= 1'b0;
        sel_q  <= '0;
        vld_q  <= 1'b0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        prev_q <= samp;
        sel_q  <= sel;
        vld_q  <= 1'b1;
        if (cfg_clr_i[n]) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end else if (hit && !acc) begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          else                  ovf_q <= 1'b1;
        end else if (!hit && acc) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end

    assign req[n]                  = (cnt_q != '0);
    assign pend[n*CNT_W +: CNT_W]  = cnt_q;
    assign ovf[n]                  = ovf_q;
  end

  assign evt.evt_req_o  = req;
  assign evt.evt_pend_o = pend;
  assign evt.evt_ovf_o  = ovf;

endmodule

// File: tb/tb_adv_timer_event_gen.sv
// Bench for adv_timer_event_gen: directed table, multi-cycle corner sequences, then random traffic vs. a counting model.
module tb_adv_timer_event_gen;
  localparam int N_SRC = 16;
  localparam int N_EVT = 4;
  localparam int SEL_W = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pwm;
  logic [3:0]  en;
  logic [15:0] sel;
  logic [7:0]  edg;
  logic [3:0]  clr;

  always #5 clk = ~clk;

  adv_timer_event_gen_if #(.N_EVT(N_EVT), .CNT_W(CNT_W)) ifc ();

  adv_timer_event_gen #(
    .N_SRC(N_SRC), .N_EVT(N_EVT), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pwm_i      (pwm),
    .cfg_en_i   (en),
    .cfg_sel_i  (sel),
    .cfg_edge_i (edg),
    .cfg_clr_i  (clr),
    .evt        (ifc)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: each line is a bounded queue of pending events plus a lost-event flag.
  int m_cnt  [N_EVT];
  bit m_ovf  [N_EVT];
  bit m_prev [N_EVT];
  int m_selq [N_EVT];
  bit m_vld  [N_EVT];

  typedef struct {
    logic [15:0] pwm;
    logic [3:0]  ack;
    int          exp_pend0;
    int          exp_req0;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pend(input int n);
    return int'(ifc.evt_pend_o[n*CNT_W +: CNT_W]);
  endfunction
  function automatic int req(input int n);
    return int'(ifc.evt_req_o[n]);
  endfunction
  function automatic int ovf(input int n);
    return int'(ifc.evt_ovf_o[n]);
  endfunction

  task automatic model_clk();
    for (int n = 0; n < N_EVT; n++) begin
      if (rst) begin
        m_cnt[n] = 0; m_ovf[n] = 0; m_prev[n] = 0; m_selq[n] = 0; m_vld[n] = 0;
      end else begin
        int s, m;
        bit samp, e, hit, take;
        s = int'(sel[n*SEL_W +: SEL_W]);
        m = int'(edg[n*2 +: 2]);
        samp = (s < N_SRC) ? pwm[s] : 1'b0;
        case (m)
          0:       e = samp && !m_prev[n];
          1:       e = !samp && m_prev[n];
          2:       e = samp != m_prev[n];
          default: e = 0;
        endcase
        hit  = en[n] && m_vld[n] && (s == m_selq[n]) && e;
        take = (m_cnt[n] > 0) && ifc.evt_ack_i[n];
        if (clr[n]) begin
          m_cnt[n] = 0; m_ovf[n] = 0;
        end else begin
          if (hit) begin
            if (m_cnt[n] + 1 > CMAX && !take) m_ovf[n] = 1;
            else                              m_cnt[n] += 1;
          end
          if (take) m_cnt[n] -= 1;
        end
        m_prev[n] = samp;
        m_selq[n] = s;
        m_vld[n]  = 1;
      end
    end
  endtask

  task automatic cyc();
    model_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < N_EVT; n++) begin
      chk({tag, "_pend"}, pend(n), m_cnt[n]);
      chk({tag, "_req"},  req(n),  (m_cnt[n] > 0) ? 1 : 0);
      chk({tag, "_ovf"},  ovf(n),  int'(m_ovf[n]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;

    tbl[0]  = '{16'h0000, 4'h0, 0, 0};
    tbl[1]  = '{16'h0020, 4'h0, 1, 1};
    tbl[2]  = '{16'h0020, 4'h1, 0, 0};
    tbl[3]  = '{16'h0020, 4'h0, 0, 0};
    tbl[4]  = '{16'h0000, 4'h0, 0, 0};
    tbl[5]  = '{16'h0020, 4'h0, 1, 1};
    tbl[6]  = '{16'h0000, 4'h0, 1, 1};
    tbl[7]  = '{16'h0020, 4'h0, 2, 1};
    tbl[8]  = '{16'h0020, 4'h1, 1, 1};
    tbl[9]  = '{16'h0000, 4'h1, 0, 0};
    tbl[10] = '{16'h0000, 4'h1, 0, 0};

    rst = 1'b1; pwm = '0; en = '0; sel = '0; edg = '0; clr = '0;
    ifc.evt_ack_i = '0;
    cyc(); cyc();
    chk("reset_pend", int'(ifc.evt_pend_o), 0);
    chk("reset_req",  int'(ifc.evt_req_o),  0);
    chk("reset_ovf",  int'(ifc.evt_ovf_o),  0);
    rst = 1'b0;
    cyc();

    // Event0: source 5, rising edges, table-driven
    en = 4'b0001; sel[3:0] = 4'd5; edg[1:0] = 2'b00;
    for (int i = 0; i < 11; i++) begin
      pwm = tbl[i].pwm;
      ifc.evt_ack_i = tbl[i].ack;
      cyc();
      chk($sformatf("tbl%0d_pend0", i), pend(0), tbl[i].exp_pend0);
      chk($sformatf("tbl%0d_req0", i),  req(0),  tbl[i].exp_req0);
    end
    pwm = '0; ifc.evt_ack_i = '0;
    cyc();

    // Event1: source 2, both edges, four toggles then a continuous drain
    en = 4'b0010; sel[7:4] = 4'd2; edg[3:2] = 2'b10;
    cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      pwm[2] = ~pwm[2];
      cyc();
    end
    chk("both_pend1", pend(1), 4);
    chk("both_req1",  req(1),  1);
    ifc.evt_ack_i[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("drain%0d_pend1", k), pend(1), 4 - k);
      chk($sformatf("drain%0d_req1", k),  req(1),  (k < 4) ? 1 : 0);
    end
    ifc.evt_ack_i = '0;
    check_all("seq_both");

    // Event2: source 9, saturation at 7 then clear (clear beats a coincident edge)
    en = 4'b0100; sel[11:8] = 4'd9; edg[5:4] = 2'b00;
    cyc();
    for (int k = 1; k <= 9; k++) begin
      pwm[9] = 1'b1; cyc();
      pwm[9] = 1'b0; cyc();
      if (k == 7) begin
        chk("sat7_pend2", pend(2), 7);
        chk("sat7_ovf2",  ovf(2),  0);
      end
      if (k == 8) chk("sat8_ovf2", ovf(2), 1);
    end
    chk("ovf_pend2", pend(2), 7);
    chk("ovf_ovf2",  ovf(2),  1);
    chk("ovf_req2",  req(2),  1);
    clr[2] = 1'b1; pwm[9] = 1'b1;
    cyc();
    clr = '0;
    chk("clr_pend2", pend(2), 0);
    chk("clr_ovf2",  ovf(2),  0);
    chk("clr_req2",  req(2),  0);
    pwm = '0;
    cyc();

    // Event3: edge coincident with accept, then accept with nothing pending
    en = 4'b1000; sel[15:12] = 4'd11; edg[7:6] = 2'b00;
    cyc();
    pwm[11] = 1'b1; cyc(); pwm[11] = 1'b0; cyc();
    pwm[11] = 1'b1; cyc(); pwm[11] = 1'b0; cyc();
    chk("coin_pre_pend3", pend(3), 2);
    pwm[11] = 1'b1; ifc.evt_ack_i[3] = 1'b1;
    cyc();
    chk("coin_pend3", pend(3), 2);
    pwm[11] = 1'b0;
    cyc(); chk("coin_dr1_pend3", pend(3), 1);
    cyc(); chk("coin_dr2_pend3", pend(3), 0);
    cyc();
    chk("underflow_pend3", pend(3), 0);
    chk("underflow_req3",  req(3),  0);
    ifc.evt_ack_i = '0;
    check_all("seq_coin");

    // Event0: select changes must not create edges
    en = 4'b0001; edg[1:0] = 2'b01; sel[3:0] = 4'd0;
    pwm = 16'h0080;
    cyc(); cyc();
    sel[3:0] = 4'd7;
    cyc(); chk("selchg_pend0", pend(0), 0);
    cyc(); chk("selchg2_pend0", pend(0), 0);
    pwm[7] = 1'b0;
    cyc(); chk("fall7_pend0", pend(0), 1);
    ifc.evt_ack_i[0] = 1'b1;
    cyc(); ifc.evt_ack_i = '0;
    chk("fall7_ack_pend0", pend(0), 0);
    pwm[7] = 1'b1; pwm[3] = 1'b0;
    cyc();
    sel[3:0] = 4'd3;
    cyc(); chk("selguard_pend0", pend(0), 0);
    cyc(); chk("selguard2_pend0", pend(0), 0);

    // Reset mid-operation with the source held high
    sel[3:0] = 4'd5; edg[1:0] = 2'b00; pwm = '0;
    cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      pwm[5] = 1'b1; cyc();
      pwm[5] = 1'b0; cyc();
    end
    chk("prerst_pend0", pend(0), 3);
    pwm[5] = 1'b1; rst = 1'b1;
    cyc();
    chk("midrst_pend", int'(ifc.evt_pend_o), 0);
    chk("midrst_req",  int'(ifc.evt_req_o),  0);
    chk("midrst_ovf",  int'(ifc.evt_ovf_o),  0);
    rst = 1'b0;
    cyc(); chk("postrst1_pend0", pend(0), 0);
    cyc(); chk("postrst2_pend0", pend(0), 0);
    pwm[5] = 1'b0; cyc();
    pwm[5] = 1'b1; cyc();
    chk("postrst_edge_pend0", pend(0), 1);
    check_all("seq_rst");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        r = $urandom; en = r[3:0]; edg = r[11:4];
        r = $urandom; sel = r[15:0];
      end
      r = $urandom & $urandom & $urandom;
      pwm = pwm ^ r[15:0];
      if ($urandom_range(0, 3) == 0) r = $urandom;
      else                           r = $urandom & $urandom & $urandom;
      ifc.evt_ack_i = r[3:0];
      r = $urandom;
      clr = ($urandom_range(0, 31) == 0) ? r[3:0] : 4'h0;
      rst = ($urandom_range(0, 499) == 0);
      cyc();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adv_timer_event_gen.md
Name: adv_timer_event_gen

Overview:
- Downstream consumer of the four adv_timer blocks' pwm_o outputs, 16 lines total.
- For each of N_EVT event lines it:
  - selects one PWM channel,
  - detects the configured edge,
  - queues occurrences in a saturating pending counter,
  - presents them to the SoC event router over a level req/ack handshake.
- It replaces the single-cycle events_o pulses with lossless, back-pressurable event delivery.

Parameters:
N_SRC, 16, number of PWM source lines (4 timers x 4 channels, {tim3,tim2,tim1,tim0}, channel 0 in LSB of each nibble)
N_EVT, 4, number of event output lines
SEL_W, 4, width of each per-event source select field
CNT_W, 3, pending counter width; max pending = 2^CNT_W-1 (7)

Ports:
clk_i  in  1  clock (HCLK domain, same as timers' clk_i)
rst_i  in  1  synchronous reset, active-high
pwm_i  in  N_SRC  timer PWM outputs, synchronous to clk_i
cfg_en_i  in  N_EVT  per-event enable
cfg_sel_i  in  N_EVT*SEL_W  per-event source index, field n = bits [n*SEL_W +: SEL_W]
cfg_edge_i  in  N_EVT*2  per-event edge mode: 00 rising, 01 falling, 10 both, 11 reserved (no events)
cfg_clr_i  in  N_EVT  per-event clear pulse
evt_req_o  out  N_EVT  event pending request to router
evt_ack_i  in  N_EVT  router accept
evt_pend_o  out  N_EVT*CNT_W  per-event pending count
evt_ovf_o  out  N_EVT  sticky overflow flag

Behaviour:
- Per event n, samp = pwm_i[sel_n]. If sel_n >= N_SRC, samp = 0.
- Registered state per event:
  - prev_q <= samp, every cycle, independent of enable.
  - sel_q <= sel_n.
  - vld_q: 0 at reset, 1 from the first cycle after reset.
- hit = cfg_en_i[n] & vld_q & (sel_n == sel_q) & edge, where edge is:
  - rising: samp & ~prev_q
  - falling: ~samp & prev_q
  - both: samp ^ prev_q
  - 11: 0
- The select guard suppresses spurious edges when the selection changes.
- acc = evt_req_o[n] & evt_ack_i[n]. Ack while req is low is ignored.
- Counter update, priority order:
  - cfg_clr_i: cnt <= 0, ovf <= 0. A hit or ack in the same cycle is discarded.
  - hit & acc: cnt unchanged.
  - hit & ~acc & cnt < max: cnt + 1.
  - hit & ~acc & cnt == max: cnt held, ovf <= 1. The event is lost.
  - ~hit & acc: cnt - 1.
- evt_req_o[n] = (cnt != 0), combinational from the counter register.
- evt_pend_o = cnt, evt_ovf_o = ovf.
- Latency: an edge on pwm_i sampled at clock edge t appears as req high / cnt+1 after edge t+1 (1 cycle).
- Ack handshake: each acc cycle consumes exactly one event. Req stays high while cnt > 0, so back-to-back acks drain one per cycle.
- Disabling (cfg_en_i = 0) stops new hits only; pending events still drain.
- Reset state:
  - cnt = 0, ovf = 0, prev_q = 0, sel_q = 0, vld_q = 0.
  - All outputs 0.
- Reset mid-operation discards all pending events. No edge is counted in the first cycle after reset is released.
- Events are fully independent; the same source may be selected by multiple events.

Test Plan:
- Event0 sel=5, rising, en: drive pwm_i[5] 0->1, hold ack low -> req0 high one cycle after the edge, pend0=1. Pulse ack one cycle -> req0=0, pend0=0.
- Event1 sel=2, both edges: toggle pwm_i[2] four times, ack low -> pend1=4. Hold ack high -> req1 drops after exactly 4 cycles.
- Overflow: event2 rising, 9 rising edges with no ack -> pend2=7, ovf2=1. Pulse cfg_clr_i[2] -> pend2=0, ovf2=0, req2=0.
- Simultaneous: pend3=2, rising edge coincident with ack -> pend3 stays 2. Ack with pend=0 -> no change, no underflow.
- Select change: pwm_i[0]=0, pwm_i[7]=1, change sel0 0->7 -> no event counted. A subsequent falling edge on pwm_i[7] in falling mode -> pend0=1.
- Reset: pend0=3, assert rst_i one cycle with pwm_i[sel] held 1 -> all pend/req/ovf 0, no event in the first cycle after release.
